aes_cbc_ctrl: RTL and testbench

AES_CBC_CTRL -- requirements
Module: aes_cbc_ctrl

---
 rtl/aes_pkg.sv | 25 ++
 rtl/aes_cbc_watchdog.sv | 30 +++
 rtl/aes_cbc_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_aes_cbc_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, key-size encodings and the CBC controller state type.
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_KEY_W = 256;

    localparam logic [1:0] MODE_128 = 2'b00;
    localparam logic [1:0] MODE_192 = 2'b01;
    localparam logic [1:0] MODE_256 = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_ISSUE,
        ST_WAIT,
        ST_OUTPUT,
        ST_ERR
    } cbc_state_t;

    // Encoding 2'b11 is reserved and rejected at configuration time.
    function automatic logic mode_valid(input logic [1:0] mode);
        return (mode == MODE_128) || (mode == MODE_192) || (mode == MODE_256);
    endfunction

endpackage

// File: rtl/aes_cbc_watchdog.sv
// Cycle counter for the core-completion wait; expired is high during the
// TIMEOUT_CYC-th consecutive enabled cycle.
module aes_cbc_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_reg;

    assign expired = en && (count_reg == LAST_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/aes_cbc_ctrl.sv
// CBC chaining controller wrapped around an AES multimode core.
// Define AES_CBC_TIMEOUT_EN to build the core-completion watchdog.
module aes_cbc_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_load,
    input  logic [1:0]           cfg_mode,
    input  logic                 cfg_encrypt,
    input  logic [AES_KEY_W-1:0] cfg_key,
    input  logic [AES_BLK_W-1:0] cfg_iv,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic                 out_last,
    output logic                 core_start,
    output logic [1:0]           core_mode,
    output logic                 core_encrypt_en,
    output logic [AES_KEY_W-1:0] core_key,
    output logic [AES_BLK_W-1:0] core_data_in,
    input  logic [AES_BLK_W-1:0] core_data_out,
    input  logic                 core_done,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_cfg
);

    cbc_state_t state_reg, state_next;

    logic [1:0]           mode_reg;
    logic                 enc_reg;
    logic [AES_KEY_W-1:0] key_reg;
    logic [AES_BLK_W-1:0] iv_reg;
    logic [AES_BLK_W-1:0] chain_reg;
    logic [AES_BLK_W-1:0] blk_reg;
    logic                 last_reg;
    logic [AES_BLK_W-1:0] core_in_reg;
    logic [AES_BLK_W-1:0] out_data_reg;
    logic                 err_cfg_reg;

    logic cfg_ok, cfg_bad, accept_fire, done_fire, out_fire, timeout_hit;
    logic [AES_BLK_W-1:0] chain_xor, dec_result;

    assign cfg_ok      = (state_reg == ST_IDLE) && cfg_load && mode_valid(cfg_mode);
    assign cfg_bad     = (state_reg == ST_IDLE) && cfg_load && !mode_valid(cfg_mode);
    assign accept_fire = (state_reg == ST_ACCEPT) && in_valid;
    assign done_fire   = (state_reg == ST_WAIT) && core_done;
    assign out_fire    = (state_reg == ST_OUTPUT) && out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < AES_BLK_W / 32; gi++) begin : g_lane
            assign chain_xor[gi*32 +: 32]  = in_data[gi*32 +: 32] ^ chain_reg[gi*32 +: 32];
            assign dec_result[gi*32 +: 32] = core_data_out[gi*32 +: 32] ^ chain_reg[gi*32 +: 32];
        end
    endgenerate

`ifdef AES_CBC_TIMEOUT_EN
    logic err_timeout_reg;

    aes_cbc_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .en     (state_reg == ST_WAIT),
        .clr    (state_reg != ST_WAIT),
        .expired(timeout_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_timeout_reg <= 1'b0;
        end else if (timeout_hit && !core_done) begin
            err_timeout_reg <= 1'b1;
        end
    end

    assign err_timeout = err_timeout_reg;
`else
    // TIMEOUT_CYC only matters when the watchdog is built.
    localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        core_start = 1'b0;
        busy       = (state_reg != ST_IDLE);
        unique case (state_reg)
            ST_IDLE:   if (cfg_ok) state_next = ST_ACCEPT;
            ST_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                core_start = 1'b1;
                state_next = ST_WAIT;
            end
            // A completion arriving on the expiry cycle still wins.
            ST_WAIT: begin
                if (core_done)        state_next = ST_OUTPUT;
                else if (timeout_hit) state_next = ST_ERR;
            end
            ST_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = last_reg ? ST_IDLE : ST_ACCEPT;
            end
            ST_ERR:    state_next = ST_ERR;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_reg     <= '0;
            enc_reg      <= 1'b0;
            key_reg      <= '0;
            iv_reg       <= '0;
            chain_reg    <= '0;
            blk_reg      <= '0;
            last_reg     <= 1'b0;
            core_in_reg  <= '0;
            out_data_reg <= '0;
            err_cfg_reg  <= 1'b0;
        end else begin
            if (cfg_ok) begin
                mode_reg  <= cfg_mode;
                enc_reg   <= cfg_encrypt;
                key_reg   <= cfg_key;
                iv_reg    <= cfg_iv;
                chain_reg <= cfg_iv;
            end
            if (cfg_bad) begin
                err_cfg_reg <= 1'b1;
            end
            // core_in_reg only changes here, so it stays put through ISSUE and WAIT.
            if (accept_fire) begin
                blk_reg     <= in_data;
                last_reg    <= in_last;
                core_in_reg <= enc_reg ? chain_xor : in_data;
            end
            if (done_fire) begin
                if (enc_reg) begin
                    out_data_reg <= core_data_out;
                    chain_reg    <= core_data_out;
                end else begin
                    out_data_reg <= dec_result;
                    chain_reg    <= blk_reg;
                end
            end
            if (out_fire && last_reg) begin
                chain_reg <= iv_reg;
            end
        end
    end

    assign out_data        = out_data_reg;
    assign out_last        = last_reg && out_valid;
    assign core_mode       = mode_reg;
    assign core_encrypt_en = enc_reg;
    assign core_key        = key_reg;
    assign core_data_in    = core_in_reg;
    assign err_cfg         = err_cfg_reg;

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Directed bench for aes_cbc_ctrl using a table-driven stand-in for the AES core.
`timescale 1ns/1ps
module tb_aes_cbc_ctrl;

    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cfg_load = 1'b0;
    logic [1:0]   cfg_mode = '0;
    logic         cfg_encrypt = 1'b0;
    logic [255:0] cfg_key = '0;
    logic [127:0] cfg_iv = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         out_last;
    logic         core_start;
    logic [1:0]   core_mode;
    logic         core_encrypt_en;
    logic [255:0] core_key;
    logic [127:0] core_data_in;
    logic [127:0] core_data_out;
    logic         core_done;
    logic         busy;
    logic         err_timeout;
    logic         err_cfg;

    int total = 0;
    int passed = 0;
    int start_cnt = 0;
    bit core_auto = 1'b1;
    int manual_req = 0;
    int manual_ack = 0;
    logic [127:0] manual_data = '0;
    logic [127:0] seen_core_in = '0;

    aes_cbc_ctrl #(.TIMEOUT_CYC(15)) dut (
        .clk(clk), .rst(rst),
        .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_encrypt(cfg_encrypt),
        .cfg_key(cfg_key), .cfg_iv(cfg_iv),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .core_start(core_start), .core_mode(core_mode), .core_encrypt_en(core_encrypt_en),
        .core_key(core_key), .core_data_in(core_data_in), .core_data_out(core_data_out),
        .core_done(core_done),
        .busy(busy), .err_timeout(err_timeout), .err_cfg(err_cfg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (core_start === 1'b1) start_cnt <= start_cnt + 1;

    // Known AES-128 pairs for the NIST CBC vectors; anything else comes back inverted.
    function automatic logic [127:0] core_model(input logic [127:0] din, input logic enc);
        logic [127:0] p1x = P1 ^ IV;
        logic [127:0] p2x = P2 ^ C1;
        if (enc) begin
            if (din == p1x) return C1;
            if (din == p2x) return C2;
        end else begin
            if (din == C1) return p1x;
            if (din == C2) return p2x;
        end
        return ~din;
    endfunction

    // Core stand-in: one-cycle latency after core_start, or a manual done pulse on request.
    initial begin
        core_done = 1'b0;
        core_data_out = '0;
        forever begin
            @(posedge clk);
            if (core_start === 1'b1 && core_auto) begin
                seen_core_in = core_data_in;
                #1;
                core_data_out = core_model(seen_core_in, core_encrypt_en);
                core_done = 1'b1;
                @(posedge clk);
                #1 core_done = 1'b0;
            end else if (manual_req != manual_ack) begin
                #1;
                core_data_out = manual_data;
                core_done = 1'b1;
                manual_ack = manual_req;
                @(posedge clk);
                #1 core_done = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    task automatic do_cfg(input logic [1:0] mode, input logic enc, input logic [255:0] key,
                          input logic [127:0] iv);
        @(negedge clk);
        cfg_load = 1'b1; cfg_mode = mode; cfg_encrypt = enc; cfg_key = key; cfg_iv = iv;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic send_blk(input logic [127:0] din, input logic last);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = din; in_last = last;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            $display("FAIL send_handshake: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (out_valid !== 1'b1 && cyc < 100);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (core_start !== 1'b0) $display("FAIL rst_core_start: got %b want 0", core_start); else passed++;
        total++; if (core_key !== 256'h0) $display("FAIL rst_core_key: got %h want 0", core_key); else passed++;
        total++; if (err_cfg !== 1'b0) $display("FAIL rst_err_cfg: got %b want 0", err_cfg); else passed++;
        total++; if (err_timeout !== 1'b0) $display("FAIL rst_err_timeout: got %b want 0", err_timeout); else passed++;
        $display("reset: busy=%b in_ready=%b out_valid=%b", busy, in_ready, out_valid);
    endtask

    task automatic test_cbc_encrypt();
        int cyc;
        do_cfg(2'b00, 1'b1, {128'h0, KEY}, IV);
        total++; if (busy !== 1'b1) $display("FAIL enc_busy: got %b want 1", busy); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL enc_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (core_key !== {128'h0, KEY}) $display("FAIL enc_core_key: got %h want %h", core_key, {128'h0, KEY}); else passed++;
        total++; if (core_encrypt_en !== 1'b1) $display("FAIL enc_core_enc: got %b want 1", core_encrypt_en); else passed++;

        send_blk(P1, 1'b0);
        wait_out(cyc);
        total++; if (cyc !== 3) $display("FAIL enc_latency: got %0d want 3", cyc); else passed++;
        total++; if (seen_core_in !== (P1 ^ IV)) $display("FAIL enc_core_in1: got %h want %h", seen_core_in, P1 ^ IV); else passed++;
        total++; if (out_data !== C1) $display("FAIL enc_out1: got %h want %h", out_data, C1); else passed++;
        total++; if (out_last !== 1'b0) $display("FAIL enc_last1: got %b want 0", out_last); else passed++;
        $display("enc blk1: out=%h last=%b", out_data, out_last);
        @(posedge clk);
        #1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL enc_back_to_back: in_ready got %b want 1", in_ready); else passed++;

        send_blk(P2, 1'b1);
        wait_out(cyc);
        total++; if (seen_core_in !== (P2 ^ C1)) $display("FAIL enc_core_in2: got %h want %h", seen_core_in, P2 ^ C1); else passed++;
        total++; if (out_data !== C2) $display("FAIL enc_out2: got %h want %h", out_data, C2); else passed++;
        total++; if (out_last !== 1'b1) $display("FAIL enc_last2: got %b want 1", out_last); else passed++;
        $display("enc blk2: out=%h last=%b", out_data, out_last);
        @(posedge clk);
        #1;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL enc_idle_after_last: busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_cbc_decrypt();
        int cyc;
        do_cfg(2'b00, 1'b0, {128'h0, KEY}, IV);
        send_blk(C1, 1'b0);
        wait_out(cyc);
        total++; if (seen_core_in !== C1) $display("FAIL dec_core_in1: got %h want %h", seen_core_in, C1); else passed++;
        total++; if (out_data !== P1) $display("FAIL dec_out1: got %h want %h", out_data, P1); else passed++;
        $display("dec blk1: out=%h last=%b", out_data, out_last);
        @(posedge clk);
        #1;
        send_blk(C2, 1'b1);
        wait_out(cyc);
        total++; if (out_data !== P2) $display("FAIL dec_out2: got %h want %h", out_data, P2); else passed++;
        total++; if (out_last !== 1'b1) $display("FAIL dec_last2: got %b want 1", out_last); else passed++;
        $display("dec blk2: out=%h last=%b", out_data, out_last);
        @(posedge clk);
        #1;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL dec_idle_after_last: busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_backpressure();
        int cyc;
        int s0;
        bit stable = 1'b1;
        out_ready = 1'b0;
        do_cfg(2'b00, 1'b1, {128'h0, KEY}, IV);
        send_blk(P1, 1'b1);
        wait_out(cyc);
        total++; if (out_data !== C1) $display("FAIL bp_out: got %h want %h", out_data, C1); else passed++;
        s0 = start_cnt;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== C1 || in_ready !== 1'b0 || out_last !== 1'b1) stable = 1'b0;
        end
        total++; if (stable !== 1'b1) $display("FAIL bp_stable: held outputs changed, last out_valid=%b out_data=%h in_ready=%b", out_valid, out_data, in_ready); else passed++;
        total++; if (start_cnt !== s0) $display("FAIL bp_core_start: starts got %0d want %0d", start_cnt, s0); else passed++;
        $display("backpressure: out=%h held 20 cycles", out_data);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_release: out_valid=%b busy=%b want 0/0", out_valid, busy); else passed++;
    endtask

    task automatic test_cfg_busy();
        int cyc;
        do_cfg(2'b00, 1'b1, {128'h0, KEY}, IV);
        do_cfg(2'b10, 1'b0, {256{1'b1}}, ~IV);
        total++; if (core_key !== {128'h0, KEY}) $display("FAIL busy_cfg_key: got %h want %h", core_key, {128'h0, KEY}); else passed++;
        total++; if (core_mode !== 2'b00) $display("FAIL busy_cfg_mode: got %b want 00", core_mode); else passed++;
        total++; if (err_cfg !== 1'b0) $display("FAIL busy_cfg_err: got %b want 0", err_cfg); else passed++;
        send_blk(P1, 1'b0);
        wait_out(cyc);
        total++; if (out_data !== C1) $display("FAIL busy_cfg_chain: got %h want %h", out_data, C1); else passed++;
        $display("cfg while busy: key=%h out=%h", core_key[127:0], out_data);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_wait();
        bit saw_valid = 1'b0;
        core_auto = 1'b0;
        send_blk(P2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL mid_wait_busy: got %b want 1", busy); else passed++;
        rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || core_start !== 1'b0)
            $display("FAIL mid_wait_rst_ctrl: busy=%b out_valid=%b in_ready=%b core_start=%b want 0", busy, out_valid, in_ready, core_start);
        else passed++;
        total++; if (core_key !== 256'h0 || core_data_in !== 128'h0 || out_data !== 128'h0 || core_encrypt_en !== 1'b0)
            $display("FAIL mid_wait_rst_data: key=%h din=%h dout=%h want 0", core_key, core_data_in, out_data);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        manual_data = 128'hfeedface_00000000_12345678_9abcdef0;
        manual_req++;
        repeat (8) begin
            @(negedge clk);
            if (out_valid !== 1'b0) saw_valid = 1'b1;
        end
        total++; if (saw_valid !== 1'b0) $display("FAIL mid_wait_late_done: out_valid seen %b want 0", saw_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL mid_wait_idle: busy got %b want 0", busy); else passed++;
        $display("reset mid-wait: busy=%b out_valid=%b", busy, out_valid);
        core_auto = 1'b1;
    endtask

    task automatic test_cfg_mode11();
        do_cfg(2'b11, 1'b1, {128'h0, KEY}, IV);
        total++; if (err_cfg !== 1'b1) $display("FAIL mode11_err: got %b want 1", err_cfg); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL mode11_idle: busy got %b want 0", busy); else passed++;
        total++; if (core_key !== 256'h0) $display("FAIL mode11_key: got %h want 0", core_key); else passed++;
        @(negedge clk);
        total++; if (err_cfg !== 1'b1) $display("FAIL mode11_sticky: got %b want 1", err_cfg); else passed++;
        $display("mode11: err_cfg=%b busy=%b", err_cfg, busy);
    endtask

    task automatic test_timeout();
`ifdef AES_CBC_TIMEOUT_EN
        bit early = 1'b0;
        bit held = 1'b1;
        apply_reset();
        core_auto = 1'b0;
        do_cfg(2'b00, 1'b1, {128'h0, KEY}, IV);
        send_blk(P1, 1'b0);
        @(negedge clk);
        total++; if (core_start !== 1'b1) $display("FAIL to_issue: core_start got %b want 1", core_start); else passed++;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (err_timeout !== 1'b0) early = 1'b1;
        end
        total++; if (early !== 1'b0) $display("FAIL to_early: err_timeout rose before 15 wait cycles"); else passed++;
        @(negedge clk);
        total++; if (err_timeout !== 1'b1) $display("FAIL to_flag: got %b want 1", err_timeout); else passed++;
        total++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL to_err_state: busy=%b in_ready=%b out_valid=%b want 1/0/0", busy, in_ready, out_valid);
        else passed++;
        manual_req++;
        repeat (6) begin
            @(negedge clk);
            if (err_timeout !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) held = 1'b0;
        end
        total++; if (held !== 1'b1) $display("FAIL to_stuck: ERR not held, err_timeout=%b out_valid=%b", err_timeout, out_valid); else passed++;
        $display("timeout: err_timeout=%b busy=%b", err_timeout, busy);
        core_auto = 1'b1;
        apply_reset();
`else
        int cyc;
        apply_reset();
        core_auto = 1'b0;
        do_cfg(2'b00, 1'b1, {128'h0, KEY}, IV);
        send_blk(P1, 1'b0);
        repeat (40) @(negedge clk);
        total++; if (busy !== 1'b1 || out_valid !== 1'b0) $display("FAIL nowd_waiting: busy=%b out_valid=%b want 1/0", busy, out_valid); else passed++;
        total++; if (err_timeout !== 1'b0) $display("FAIL nowd_err: got %b want 0", err_timeout); else passed++;
        manual_data = 128'h0123456789abcdeffedcba9876543210;
        manual_req++;
        wait_out(cyc);
        total++; if (out_valid !== 1'b1 || out_data !== manual_data)
            $display("FAIL nowd_late_done: out_valid=%b out=%h want 1/%h", out_valid, out_data, manual_data);
        else passed++;
        $display("long wait: out=%h err_timeout=%b", out_data, err_timeout);
        @(posedge clk);
        #1;
        core_auto = 1'b1;
        apply_reset();
`endif
    endtask

    initial begin
        test_reset();
        test_cbc_encrypt();
        test_cbc_decrypt();
        test_backpressure();
        test_cfg_busy();
        test_reset_mid_wait();
        test_cfg_mode11();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
